// File: rtl/alu_exec_stage.sv
// Two-stage execute/writeback stage that feeds an external 32-bit ALU and writes its result to an internal register file.
// Optional macro ALU_EXEC_FORWARD_EN enables operand forwarding; when it is undefined, dependent ops stall instead.
module alu_exec_stage #(
  parameter bit REGFILE_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_opcode,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  input  logic        in_use_imm,
  output logic [2:0]  alu_opcode,
  output logic [31:0] alu_left,
  output logic [31:0] alu_right,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data
);

  logic        e_valid;
  logic [4:0]  e_rd;
  logic [31:0] rf [32];

  logic        w_free;
  logic        retire;
  logic        accept;
  logic        hazard_stall;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  assign w_free = !out_valid || out_ready;
  assign retire = out_valid && out_ready;

`ifdef ALU_EXEC_FORWARD_EN
  // Youngest producer wins: E (still in the ALU) ahead of W ahead of the register file.
  function automatic logic [31:0] read_src(input logic [4:0] idx, input logic [31:0] rf_val);
    if (idx == '0)                        return '0;
    else if (e_valid && e_rd == idx)      return alu_result;
    else if (out_valid && out_rd == idx)  return out_data;
    else                                  return rf_val;
  endfunction

  assign hazard_stall = 1'b0;
`else
  function automatic logic [31:0] read_src(input logic [4:0] idx, input logic [31:0] rf_val);
    return (idx == '0) ? '0 : rf_val;
  endfunction

  function automatic logic busy(input logic [4:0] idx);
    return (idx != '0) && ((e_valid && e_rd == idx) || (out_valid && out_rd == idx));
  endfunction

  assign hazard_stall = busy(in_rs1) || (!in_use_imm && busy(in_rs2));
`endif

  assign in_ready = (!e_valid || w_free) && !hazard_stall;
  assign accept   = in_valid && in_ready;

  always_comb begin
    rs1_val = read_src(in_rs1, rf[in_rs1]);
    rs2_val = read_src(in_rs2, rf[in_rs2]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid    <= 1'b0;
      e_rd       <= '0;
      alu_opcode <= '0;
      alu_left   <= '0;
      alu_right  <= '0;
      out_valid  <= 1'b0;
      out_rd     <= '0;
      out_data   <= '0;
    end else begin
      if (w_free) begin
        out_valid <= e_valid;
        if (e_valid) begin
          out_data <= alu_result;
          out_rd   <= e_rd;
        end
      end
      if (accept) begin
        e_valid    <= 1'b1;
        e_rd       <= in_rd;
        alu_opcode <= in_opcode;
        alu_left   <= rs1_val;
        alu_right  <= in_use_imm ? in_imm : rs2_val;
      end else if (e_valid && w_free) begin
        e_valid <= 1'b0;
      end
    end
  end

  generate
    if (REGFILE_RESET) begin : g_rf_rst
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          rf <= '{default: '0};
        else if (retire && out_rd != '0)
          rf[out_rd] <= out_data;
      end
    end else begin : g_rf_norst
      // x0 is never written; reads of index 0 are forced to zero above.
      always_ff @(posedge clk) begin
        if (retire && out_rd != '0)
          rf[out_rd] <= out_data;
      end
    end
  endgenerate

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: architectural register model predicts each result at issue, monitor compares at retire.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_opcode = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_imm = '0;
  logic        in_use_imm = 1'b0;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_left;
  logic [31:0] alu_right;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_rd;
  logic [31:0] out_data;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];
  logic [31:0] regs [32];
  bit          rand_ready = 1'b0;
  bit          held = 1'b0;
  logic [4:0]  held_rd;
  logic [31:0] held_data;

  alu_exec_stage #(.REGFILE_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .alu_opcode(alu_opcode), .alu_left(alu_left), .alu_right(alu_right),
    .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b111:  return a & b;
      3'b110:  return a | b;
      3'b100:  return a - b;
      default: return 32'd0;
    endcase
  endfunction

  // Environment ALU driven by the DUT's registered outputs.
  always_comb alu_result = alu_ref(alu_opcode, alu_left, alu_right);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_rd", {27'd0, out_rd}, {27'd0, held_rd});
        check("hold_data", out_data, held_data);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual rd=%0d data=%h required none", out_rd, out_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("result_rd", {27'd0, out_rd}, {27'd0, e.rd});
          check("result_data", out_data, e.data);
        end
      end
      held      = out_valid && !out_ready;
      held_rd   = out_rd;
      held_data = out_data;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic issue(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic ui,
                       output int stalls);
    logic [31:0] a, b, r;
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_use_imm = ui;
    stalls = 0;
    @(negedge clk);
    while (!in_ready && stalls < 60) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout actual in_ready=0 required in_ready=1");
      in_valid = 1'b0;
      return;
    end
    a = (rs1 == 0) ? 32'd0 : regs[rs1];
    b = ui ? imm : ((rs2 == 0) ? 32'd0 : regs[rs2]);
    r = alu_ref(op, a, b);
    if (rd != 0) regs[rd] = r;
    q.push_back('{rd: rd, data: r});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    rand_ready = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    int st;
    for (int i = 0; i < 32; i++) regs[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_alu_opcode", {29'd0, alu_opcode}, 0);
    check("rst_alu_left", alu_left, 0);
    check("rst_alu_right", alu_right, 0);
    check("rst_out_rd", {27'd0, out_rd}, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 1);

    // First op: latency of two edges from accept to out_valid.
    issue(3'b000, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, st);
    check("lat_stall", st, 0);
    check("lat_e_left", alu_left, 0);
    check("lat_e_right", alu_right, 5);
    check("lat_w_empty0", {31'd0, out_valid}, 0);
    @(posedge clk); #1;
    check("lat_w_valid", {31'd0, out_valid}, 1);
    check("lat_w_rd", {27'd0, out_rd}, 1);
    check("lat_w_data", out_data, 5);
    drain();

    // Register operands through SUB / AND / OR.
    issue(3'b000, 5'd3, 5'd0, 5'd0, 32'd10, 1'b1, st);
    issue(3'b000, 5'd4, 5'd0, 5'd0, 32'd3, 1'b1, st);
    issue(3'b100, 5'd5, 5'd3, 5'd4, 32'd0, 1'b0, st);
    issue(3'b111, 5'd5, 5'd3, 5'd4, 32'd0, 1'b0, st);
    issue(3'b110, 5'd5, 5'd3, 5'd4, 32'd0, 1'b0, st);
    drain();

    // Dependent op directly behind its producer.
    issue(3'b000, 5'd1, 5'd0, 5'd0, 32'd7, 1'b1, st);
    issue(3'b000, 5'd2, 5'd1, 5'd1, 32'd0, 1'b0, st);
`ifdef ALU_EXEC_FORWARD_EN
    check("dep_stall", st, 0);
`else
    check("dep_stall", st, 2);
`endif
    drain();

    // Backpressure: E and W fill, third op waits, results held then released in order.
    out_ready = 1'b0;
    issue(3'b000, 5'd11, 5'd0, 5'd0, 32'd1, 1'b1, st);
    issue(3'b000, 5'd12, 5'd0, 5'd0, 32'd2, 1'b1, st);
    fork
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join_none
    issue(3'b000, 5'd13, 5'd0, 5'd0, 32'd3, 1'b1, st);
    check("bp_in_ready_dropped", {31'd0, st > 0}, 1);
    drain();

    // Writes to x0 appear on the output but never land in the register file.
    issue(3'b000, 5'd0, 5'd0, 5'd0, 32'd9, 1'b1, st);
    issue(3'b000, 5'd6, 5'd0, 5'd0, 32'd0, 1'b0, st);
    drain();

    // Randomized traffic with random backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      issue(3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)), st);
    end
    drain();

    // Reset while E and W both hold ops targeting x9.
    out_ready = 1'b0;
    issue(3'b000, 5'd9, 5'd0, 5'd0, 32'h55, 1'b1, st);
    issue(3'b000, 5'd9, 5'd0, 5'd0, 32'h66, 1'b1, st);
    check("mid_w_valid", {31'd0, out_valid}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 0);
    q.delete();
    for (int i = 0; i < 32; i++) regs[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    issue(3'b000, 5'd10, 5'd9, 5'd0, 32'd0, 1'b0, st);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
